// File: rtl/fixed_math_pkg.sv
// Shared fixed-point constants and the saturating product-rescale helper used by
// the multiplier scheduler.
package fixed_math_pkg;

  localparam int FIX_WIDTH = 32;
  localparam int FIX_FRAC  = 12;
  localparam int FIX_MAX_W = 64;

  typedef logic signed [2*FIX_MAX_W-1:0] fix_prod_t;

  // Rescales a full-width product by 2^-frac (floor) and clamps it to a signed
  // width-bit range. Returns {ovf, data}; data sits in the low width bits.
  function automatic logic [FIX_MAX_W:0] fix_sat(input fix_prod_t p, input int width,
                                                 input int frac);
    fix_prod_t           s;
    fix_prod_t           hi;
    fix_prod_t           lo;
    logic [FIX_MAX_W:0]  r;
    s  = p >>> frac;
    hi = (fix_prod_t'(1) <<< (width - 1)) - fix_prod_t'(1);
    lo = -(fix_prod_t'(1) <<< (width - 1));
    if (s > hi) begin
      r = {1'b1, hi[FIX_MAX_W-1:0]};
    end else if (s < lo) begin
      r = {1'b1, lo[FIX_MAX_W-1:0]};
    end else begin
      r = {1'b0, s[FIX_MAX_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from rr_ptr, which moves
// just past each winner and stays put on idle cycles.
module mul_rr_arbiter import fixed_math_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_vld
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;

  // NOTE: every output of this block gets a default before the search loop, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld && !rst && req_valid[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/fixed_mul_scheduler.sv
// Shares one two-stage signed fixed-point multiplier among N_REQ requesters;
// results come back saturated and tagged with the owner two edges after accept.
module fixed_mul_scheduler import fixed_math_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0]      req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0]      req_b,
  output logic                             resp_valid,
  output logic [$clog2(N_REQ)-1:0]         resp_id,
  output logic [WIDTH-1:0]                 resp_data,
  output logic                             resp_ovf
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;

  mul_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;

  logic                    s1_vld_q;
  logic [ID_W-1:0]         s1_id_q;
  logic signed [WIDTH-1:0] s1_a_q;
  logic signed [WIDTH-1:0] s1_b_q;

  // NOTE: only the valid bit is reset; operand flops are qualified by it, so
  // leaving the datapath unreset is safe and keeps reset fan-out small.
  always_ff @(posedge clk) begin
    if (rst) s1_vld_q <= 1'b0;
    else     s1_vld_q <= grant_vld;
    if (grant_vld) begin
      s1_id_q <= grant_id;
      s1_a_q  <= req_a[grant_id];
      s1_b_q  <= req_b[grant_id];
    end
  end

  logic signed [2*WIDTH-1:0] prod;
  logic [FIX_MAX_W:0]        sat_res;
  logic                      sat_unused;
  logic [WIDTH-1:0]          resp_data_d;
  logic                      resp_ovf_d;

  assign prod        = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);
  assign sat_res     = fix_sat(fix_prod_t'(prod), WIDTH, FRAC);
  assign resp_data_d = sat_res[WIDTH-1:0];
  assign resp_ovf_d  = sat_res[FIX_MAX_W];
  // Upper data bits only repeat the sign of the clamped value.
  assign sat_unused  = ^sat_res[FIX_MAX_W-1:WIDTH-1];

  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_ovf_q;

  // Tag/data/ovf hold their last value whenever no result is emerging.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      resp_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        resp_id_q   <= s1_id_q;
        resp_data_q <= resp_data_d;
        resp_ovf_q  <= resp_ovf_d;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_ovf   = resp_ovf_q;

endmodule

// File: doc/fixed_mul_scheduler.md
# fixed_mul_scheduler

Shares one pipelined signed fixed-point multiplier among N_REQ effect stages (gain, mixer, filter taps) in the guitar processing chain. Requesters present operand pairs with a valid/ready handshake, and a round-robin arbiter grants one request per cycle. The block returns the saturated Q(WIDTH-FRAC).FRAC product, tagged with the requester ID, exactly 2 cycles after acceptance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width, two's complement
- FRAC, 12, fractional bits (1.0 = 2^FRAC = 4096)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has an operand pair
- req_ready  out  N_REQ  one-hot grant; transfer when valid & ready
- req_a  in  N_REQ×WIDTH  multiplicand per requester, signed
- req_b  in  N_REQ×WIDTH  multiplier per requester, signed
- resp_valid  out  1  result strobe, one cycle per accepted request
- resp_id  out  $clog2(N_REQ)  index of the requester that owns the result
- resp_data  out  WIDTH  saturated fixed-point product
- resp_ovf  out  1  saturation occurred for this result

## Operation
- Arbitration: combinational search from rr_ptr upward (mod N_REQ) for the first req_valid. req_ready[g]=1 only for the winner g; all other ready bits are 0. If no valid is asserted, all ready bits are 0.
- rr_ptr: resets to 0. After a grant it becomes (g+1) mod N_REQ. It is unchanged on idle cycles.
- A requester holds valid and operands stable until ready. Dropping valid before the grant is legal, and the request is simply not served.
- Stage S1 (accept edge): register a, b, id and a valid bit.
- Stage S2: full signed product p = a*b (2*WIDTH bits), then s = p >>> FRAC (arithmetic shift, floor toward −inf).
  - If s > 2^(WIDTH-1)−1: resp_data = max positive, resp_ovf = 1.
  - If s < −2^(WIDTH-1): resp_data = most negative, resp_ovf = 1.
  - Otherwise resp_data = s[WIDTH-1:0], resp_ovf = 0.
- Outputs are registered. There is no response backpressure: consumers must take the result in its valid cycle.
- Output hold: when resp_valid=0, resp_id, resp_data and resp_ovf hold their last values.

## Timing
- Reset values: resp_valid=0, resp_id=0, resp_data=0, resp_ovf=0, rr_ptr=0, pipeline valid bits=0.
- Reset behaviour: rst clears in-flight results; no resp_valid appears for requests accepted before the reset. req_ready is 0 in every cycle with rst=1.
- Latency: handshake at edge T gives resp_valid=1 in the cycle after edge T+1 (2 edges).
- Throughput: 1 result/cycle. Results return in grant order.
- Simultaneous events: with all requesters valid continuously, grants follow strict rotation and each requester waits at most N_REQ−1 cycles. A new request from the requester whose result is currently emerging is legal in the same cycle.

## Structure
- Package fixed_math_pkg holds:
  - defaults FIX_WIDTH=32 and FIX_FRAC=12;
  - function fix_sat(p, width, frac) returning {ovf, data};
  - localparam ID_W = $clog2(N_REQ) computed in-block.
- Sub-module mul_rr_arbiter (parameter N_REQ; ports: clk, rst, req_valid, grant one-hot, grant_id, grant_vld) owns rr_ptr.
- The top level holds the two pipeline stages and the saturation logic.

## Test plan
- Basic product: a=8192 (2.0), b=6144 (1.5) on requester 0, others idle. Two edges later: resp_valid=1, resp_id=0, resp_data=12288, resp_ovf=0.
- Sign and floor:
  - a=−4096, b=6144 on requester 2 gives −6144.
  - a=−1, b=1 gives −1.
  - a=1, b=1 gives 0. All with ovf=0.
- Saturation: a=b=0x7FFFFFFF gives 0x7FFFFFFF, ovf=1. a=0x80000000, b=0x7FFFFFFF gives 0x80000000, ovf=1.
- Round-robin:
  - All 4 valid for 8 cycles: grants 0,1,2,3,0,1,2,3, and resp_id repeats that sequence from cycle 2.
  - Then only requester 1 valid: granted every cycle.
- Fairness after idle: grant 2, then 3 idle cycles, then valid on 0 and 3 together. Requester 3 is granted first (rr_ptr=3), then requester 0.
- Reset mid-operation: accept 2 back-to-back requests, then assert rst for 1 cycle at the next edge. No resp_valid follows and all outputs are 0. The next request with all valid is granted to requester 0.
